// File: rtl/audio_i2s_tx_if.sv
// Sample handshake between the effects chain and the I2S transmitter.
// The upstream block drives the run request and samples; the transmitter returns the capture pulse.
interface audio_i2s_tx_if;
  logic               enable;
  logic signed [31:0] in_L;
  logic signed [31:0] in_R;
  logic               sample_req;

  modport master (output enable, output in_L, output in_R, input sample_req);
  modport slave  (input enable, input in_L, input in_R, output sample_req);
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S stereo transmitter: 64-slot frames, 24 data bits + 8 zero bits per word, one-BCLK data delay.
// Define I2S_TX_ROUND_EN to round and saturate captured samples to 24 bits instead of truncating.
//
// state | meaning
// IDLE  | all outputs, divider and frame position held at 0
// RUN   | BCLK running; frames serialized until enable drops at a frame end
module audio_i2s_tx #(
  parameter int BCLK_HALF_DIV = 8
) (
  input  logic           CLOCK_50,
  input  logic           reset_n,
  audio_i2s_tx_if.slave  smp,
  output logic           AUD_BCLK,
  output logic           AUD_DACLRCK,
  output logic           AUD_DACDAT
);

  localparam logic [7:0] DIV_TC = 8'(BCLK_HALF_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  div, div_nxt;
  logic [5:0]  p, p_nxt;
  logic        first, first_nxt;
  logic [31:0] sh_l, sh_l_nxt;
  logic [31:0] sh_r, sh_r_nxt;
  logic        bclk_nxt, lrck_nxt, dat_nxt;
  logic        tc, fall, wrap, cap;
  logic [4:0]  bit_idx;

  function automatic logic [31:0] fmt_word(input logic [31:0] s);
`ifdef I2S_TX_ROUND_EN
    logic [32:0] sum;
    logic [31:0] sat;
    sum = {s[31], s} + 33'h0_0000_0080;
    // Only positive overflow is reachable when adding a positive constant.
    if (sum[32] != sum[31])
      sat = sum[32] ? 32'h8000_0000 : 32'h7FFF_FF00;
    else
      sat = sum[31:0];
    return sat & 32'hFFFF_FF00;
`else
    return s & 32'hFFFF_FF00;
`endif
  endfunction

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      div         <= 8'd0;
      p           <= 6'd0;
      first       <= 1'b1;
      sh_l        <= 32'd0;
      sh_r        <= 32'd0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
    end else begin
      state       <= state_nxt;
      div         <= div_nxt;
      p           <= p_nxt;
      first       <= first_nxt;
      sh_l        <= sh_l_nxt;
      sh_r        <= sh_r_nxt;
      AUD_BCLK    <= bclk_nxt;
      AUD_DACLRCK <= lrck_nxt;
      AUD_DACDAT  <= dat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    p_nxt     = p;
    first_nxt = first;
    sh_l_nxt  = sh_l;
    sh_r_nxt  = sh_r;
    bclk_nxt  = AUD_BCLK;
    lrck_nxt  = AUD_DACLRCK;
    dat_nxt   = AUD_DACDAT;
    cap       = 1'b0;
    bit_idx   = 5'd0;
    tc        = (div == DIV_TC);
    fall      = tc && AUD_BCLK;
    // Frame boundary: the first falling edge after start, or the one after slot 63.
    wrap      = fall && (first || (p == 6'd63));

    case (state)
      IDLE: begin
        div_nxt   = 8'd0;
        p_nxt     = 6'd0;
        first_nxt = 1'b1;
        bclk_nxt  = 1'b0;
        lrck_nxt  = 1'b0;
        dat_nxt   = 1'b0;
        if (smp.enable)
          state_nxt = RUN;
      end
      RUN: begin
        div_nxt = tc ? 8'd0 : div + 8'd1;
        if (tc)
          bclk_nxt = ~AUD_BCLK;
        if (wrap && !smp.enable) begin
          state_nxt = IDLE;
          div_nxt   = 8'd0;
          p_nxt     = 6'd0;
          bclk_nxt  = 1'b0;
          lrck_nxt  = 1'b0;
          dat_nxt   = 1'b0;
        end else if (fall) begin
          cap       = wrap;
          first_nxt = 1'b0;
          p_nxt     = first ? 6'd0 : p + 6'd1;
          if (wrap) begin
            sh_l_nxt = fmt_word(smp.in_L);
            sh_r_nxt = fmt_word(smp.in_R);
          end
          lrck_nxt = p_nxt[5];
          // Slot p carries word bit (32 - p) mod 32; slot 0 repeats the old right LSB.
          bit_idx  = 5'(~p_nxt[4:0] + 5'd1);
          if ((p_nxt != 6'd0) && (p_nxt <= 6'd32))
            dat_nxt = sh_l[bit_idx];
          else
            dat_nxt = sh_r[bit_idx];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign smp.sample_req = cap;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: vector table per frame, slot scoreboard, stop/restart/reset sequences.
module tb_audio_i2s_tx;

  localparam int HD = 8;

  logic CLOCK_50;
  logic reset_n;
  logic AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;

  audio_i2s_tx_if smp ();

  audio_i2s_tx #(.BCLK_HALF_DIV(HD)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .smp        (smp),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT (AUD_DACDAT)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  typedef struct packed {
    logic lrck;
    logic dat;
  } slot_t;

  vec_t        vt [5];
  slot_t       sb [$];
  int          n_chk;
  int          n_fail;
  logic [23:0] exp_l, exp_r;
  longint      cyc;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input int i);
    smp.in_L = vt[i].l;
    smp.in_R = vt[i].r;
    exp_l    = vt[i].el;
    exp_r    = vt[i].er;
  endtask

  task automatic wait_sreq(input string name);
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLOCK_50);
      if (smp.sample_req) break;
    end
    chk({name, " sample_req seen"}, {31'd0, smp.sample_req}, 32'd1);
  endtask

  task automatic wait_falls(input int n);
    int   cnt;
    logic pb;
    cnt = 0;
    pb  = AUD_BCLK;
    for (int k = 0; (k < n * 4 * HD + 64) && (cnt < n); k++) begin
      @(negedge CLOCK_50);
      if (pb && !AUD_BCLK) cnt++;
      pb = AUD_BCLK;
    end
    chk("bclk falls reached", cnt, n);
  endtask

  task automatic idle_check(input string name, input int ncyc);
    int bad;
    bad = 0;
    repeat (ncyc) begin
      @(negedge CLOCK_50);
      if (AUD_BCLK || AUD_DACLRCK || AUD_DACDAT || smp.sample_req) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic start_latency(input string name);
    int n;
    n = 0;
    @(posedge CLOCK_50);
    #1 smp.enable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLOCK_50);
      if (smp.sample_req) break;
      @(posedge CLOCK_50);
      n++;
    end
    chk({name, " first capture latency"}, n, 2 * HD);
  endtask

  // Monitor thread state
  logic   prev_bclk, prev_lrck, prev_dat;
  logic   have_rise, have_sreq;
  longint last_rise, last_sreq;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    vt[0] = '{32'h1234_5678, 32'h8765_4321, 24'h123456, 24'h876543};
`ifdef I2S_TX_ROUND_EN
    vt[1] = '{32'h7FFF_FFF0, 32'h0000_00C0, 24'h7FFFFF, 24'h000001};
    vt[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 24'h800000, 24'h000000};
    vt[3] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 24'hA5A5A6, 24'h5A5A5A};
    vt[4] = '{32'h0000_00FF, 32'h7FFF_FF7F, 24'h000001, 24'h7FFFFF};
`else
    vt[1] = '{32'h7FFF_FFF0, 32'h0000_00C0, 24'h7FFFFF, 24'h000000};
    vt[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 24'h800000, 24'hFFFFFF};
    vt[3] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 24'hA5A5A5, 24'h5A5A5A};
    vt[4] = '{32'h0000_00FF, 32'h7FFF_FF7F, 24'h000000, 24'h7FFFFF};
`endif
    reset_n    = 1'b0;
    smp.enable = 1'b0;
    drive_vec(0);

    fork
      forever begin
        @(negedge CLOCK_50);
        if (!reset_n) begin
          sb.delete();
          have_rise = 1'b0;
          have_sreq = 1'b0;
          prev_bclk = 1'b0;
          prev_lrck = 1'b0;
          prev_dat  = 1'b0;
        end else begin
          automatic logic  fall = prev_bclk && !AUD_BCLK;
          automatic logic  rise = !prev_bclk && AUD_BCLK;
          automatic slot_t s;
          automatic int    p;
          if (fall) begin
            if (sb.size() > 0) begin
              p = 64 - sb.size();
              s = sb.pop_front();
              chk($sformatf("lrck p=%0d", p), {31'd0, AUD_DACLRCK}, {31'd0, s.lrck});
              chk($sformatf("dat p=%0d", p), {31'd0, AUD_DACDAT}, {31'd0, s.dat});
            end else begin
              chk("idle after frame", {30'd0, AUD_DACLRCK, AUD_DACDAT}, 32'd0);
            end
          end
          if (AUD_DACLRCK != prev_lrck)
            chk("lrck edge on bclk fall", {31'd0, fall}, 32'd1);
          if (AUD_DACDAT != prev_dat)
            chk("dat edge on bclk fall", {31'd0, fall}, 32'd1);
          if (rise) begin
            if (have_rise) chk("bclk period", 32'(cyc - last_rise), 2 * HD);
            last_rise = cyc;
            have_rise = 1'b1;
          end
          if (smp.sample_req) begin
            automatic logic [31:0] wl = {exp_l, 8'h00};
            automatic logic [31:0] wr = {exp_r, 8'h00};
            if (have_sreq) chk("sample_req period", 32'(cyc - last_sreq), 128 * HD);
            last_sreq = cyc;
            have_sreq = 1'b1;
            for (int q = 0; q < 64; q++) begin
              s.lrck = (q >= 32);
              if (q == 0)       s.dat = 1'b0;
              else if (q <= 32) s.dat = wl[32 - q];
              else              s.dat = wr[64 - q];
              sb.push_back(s);
            end
          end
          if (!smp.enable) begin
            have_rise = 1'b0;
            have_sreq = 1'b0;
          end
          prev_bclk = AUD_BCLK;
          prev_lrck = AUD_DACLRCK;
          prev_dat  = AUD_DACDAT;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset bclk", {31'd0, AUD_BCLK}, 32'd0);
    chk("reset lrck", {31'd0, AUD_DACLRCK}, 32'd0);
    chk("reset dat", {31'd0, AUD_DACDAT}, 32'd0);
    chk("reset sample_req", {31'd0, smp.sample_req}, 32'd0);
    reset_n = 1'b1;
    idle_check("idle before enable", 50);

    // Table-driven frames, enable held continuously
    start_latency("startup");
    for (int i = 1; i < 5; i++) begin
      @(posedge CLOCK_50);
      #1 drive_vec(i);
      wait_sreq($sformatf("vector %0d", i));
    end

    // Drop enable at p=10, re-raise exactly on the frame-end edge
    wait_falls(11);
    smp.enable = 1'b0;
    drive_vec(0);
    wait_falls(53);
    repeat (2 * HD - 1) @(posedge CLOCK_50);
    #1 smp.enable = 1'b1;
    @(negedge CLOCK_50);
    chk("reassert keeps running", {31'd0, smp.sample_req}, 32'd1);

    // Drop enable at p=10 and let the frame finish into IDLE
    wait_falls(11);
    smp.enable = 1'b0;
    wait_falls(54);
    idle_check("idle after stop", 2048);
    chk("scoreboard drained after stop", sb.size(), 0);

    // Reset at p=40
    @(posedge CLOCK_50);
    #1 drive_vec(3);
    smp.enable = 1'b1;
    wait_sreq("pre-reset frame");
    wait_falls(41);
    @(posedge CLOCK_50);
    #2 reset_n = 1'b0;
    #1;
    chk("abort bclk", {31'd0, AUD_BCLK}, 32'd0);
    chk("abort lrck", {31'd0, AUD_DACLRCK}, 32'd0);
    chk("abort dat", {31'd0, AUD_DACDAT}, 32'd0);
    chk("abort sample_req", {31'd0, smp.sample_req}, 32'd0);
    smp.enable = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1 reset_n = 1'b1;
    idle_check("idle after reset release", 200);

    drive_vec(1);
    start_latency("restart");
    @(posedge CLOCK_50);
    #1 smp.enable = 1'b0;
    repeat (160 * HD) @(posedge CLOCK_50);
    chk("scoreboard drained at end", sb.size(), 0);
    idle_check("idle at end", 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_HALF_DIV, default 8: the number of CLOCK_50 cycles per BCLK half-period; legal range 2..255.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: run request for the serializer.
REQ-005 SHALL have port in_L, input, signed 32 bits: left sample from the effects chain.
REQ-006 SHALL have port in_R, input, signed 32 bits: right sample from the effects chain.
REQ-007 SHALL have port sample_req, output, 1 bit: a one-cycle pulse marking the cycle in which in_L and in_R are captured.
REQ-008 SHALL have port AUD_BCLK, output, 1 bit: I2S bit clock.
REQ-009 SHALL have port AUD_DACLRCK, output, 1 bit: word select; 0 selects left, 1 selects right.
REQ-010 SHALL have port AUD_DACDAT, output, 1 bit: serial data.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and RUN.
REQ-012 In IDLE, SHALL hold AUD_BCLK, AUD_DACLRCK and AUD_DACDAT at 0, hold the divider and the frame position p at 0, and keep sample_req at 0.
REQ-013 On IDLE with enable=1, SHALL move to RUN on the next cycle.
REQ-014 In RUN, SHALL count the divider 0..BCLK_HALF_DIV-1 and toggle AUD_BCLK when the divider is at its terminal count.
REQ-015 SHALL advance p (6 bits, 0..63, wrapping 63->0) on each BCLK falling edge; all outputs change only on falling edges.
REQ-016 SHALL drive AUD_DACLRCK to 1 for p in 32..63 and to 0 for p in 0..31.
REQ-017 SHALL drive AUD_DACDAT with word bit 31-(p-1) of the left word for p=1..32, bit 31-(p-33) of the right word for p=33..63, and the right-word LSB of the previous frame at p=0 (the standard I2S one-BCLK delay).
REQ-018 On the falling edge that sets p to 0, SHALL capture in_L and in_R into shadow registers and assert sample_req for exactly that CLOCK_50 cycle; the upstream block must hold its outputs stable at that edge.
REQ-019 SHALL present the captured left MSB on AUD_DACDAT 2*BCLK_HALF_DIV CLOCK_50 cycles after the sample_req pulse.
REQ-020 SHALL form each serialized word as bits [31:8] of the (optionally rounded) sample, followed by 8 zero bits.
REQ-021 On enable deasserting mid-frame, SHALL finish the current frame through p=63, then return to IDLE at the next falling edge; no partial frame is emitted and no sample_req is issued.
REQ-022 On enable reasserting in the same cycle as the frame-end falling edge, SHALL stay in RUN and continue with p=0, without passing through IDLE.
REQ-023 The first frame after IDLE->RUN SHALL capture at its first falling edge; p=0 of that frame carries 0 on AUD_DACDAT.

Reset
REQ-024 While reset_n=0, SHALL force state IDLE, divider 0, p 0, shadow registers 0, AUD_BCLK 0, AUD_DACLRCK 0, AUD_DACDAT 0 and sample_req 0, asynchronously.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no tail bits emitted.
REQ-026 After reset release, SHALL sit in IDLE until enable=1 is sampled.

Configuration
REQ-027 With macro I2S_TX_ROUND_EN defined, SHALL round each captured sample to 24 bits by adding 0x80 to the 33-bit sign-extended value and saturate to 0x7FFFFF00 / 0x80000000 before taking bits [31:8].
REQ-028 Without I2S_TX_ROUND_EN, SHALL truncate, using bits [31:8] directly.

Verification
REQ-029 Reset, then enable=1, in_L=0x12345678, in_R=0x87654321: on the first frame, LRCK low carries bits 0x123456 then 8 zeros and LRCK high carries 0x876543 then 8 zeros.
REQ-030 Measure the sample_req period with BCLK_HALF_DIV=8 -> exactly 1024 CLOCK_50 cycles; the AUD_BCLK period is 16 cycles.
REQ-031 Deassert enable when p=10 -> the frame completes through p=63, then all outputs are 0 and sample_req stays 0.
REQ-032 Assert reset_n=0 at p=40 -> all outputs are 0 within the same cycle; after release, the block remains in IDLE until enable=1.
REQ-033 With I2S_TX_ROUND_EN and in_L=0x7FFFFFF0 -> left word 0x7FFFFF (saturated); with in_L=0x000000C0 -> 0x000001; without the macro -> 0x7FFFFF and 0x000000.
REQ-034 Hold enable=1 continuously for 3 frames -> each p=0 DACDAT bit equals the prior frame's right LSB-slot bit (0), and LRCK edges coincide with BCLK falling edges.
